// File: rtl/hazard_pkg.sv
// Shared types and constants for the hazard/forwarding controller.
package hazard_pkg;

  localparam int NUM_REGS_DEF = 32;
  localparam int REG_AW       = $clog2(NUM_REGS_DEF);
  localparam int MAX_OUT_DEF  = 4;

  typedef logic [REG_AW-1:0] reg_addr_t;

  typedef enum logic [1:0] {
    FWD_RF = 2'b00,
    FWD_W  = 2'b01,
    FWD_M  = 2'b10
  } fwd_sel_t;

  // Outstanding-counter width able to hold 0..max_out inclusive.
  function automatic int out_width(input int max_out);
    return (max_out < 1) ? 1 : $clog2(max_out + 1);
  endfunction

endpackage

// File: rtl/hazard_scoreboard.sv
// Busy-register scoreboard for variable-latency units: busy vector,
// outstanding-op counter and sticky protocol-error flag.
module hazard_scoreboard
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int MAX_OUT  = MAX_OUT_DEF,
  parameter int OW       = out_width(MAX_OUT)
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                lat_issue,
  input  logic [AW-1:0]       issue_rd,
  input  logic                lat_done,
  input  logic [AW-1:0]       lat_done_rd,
  output logic [NUM_REGS-1:0] busy,
  output logic [OW-1:0]       outstanding,
  output logic                err_spurious
);

  localparam logic [AW-1:0] ZERO_ADDR = {AW{1'b0}};
  localparam logic [OW-1:0] OUT_MAX   = OW'(MAX_OUT);
  localparam logic [OW-1:0] OUT_ZERO  = {OW{1'b0}};
  localparam logic [OW-1:0] OUT_ONE   = OW'(1);

  logic [NUM_REGS-1:0] busy_q, busy_d;
  logic [OW-1:0]       outstanding_q, outstanding_d;
  logic                err_q, err_d;
  logic                spurious_s, overflow_s, underflow_s;

  // Next busy vector: clear on writeback first so a same-cycle issue to that register wins.
  always_comb begin
    busy_d = busy_q;
    if (lat_done && (lat_done_rd != ZERO_ADDR)) begin
      busy_d[lat_done_rd] = 1'b0;
    end else begin
      busy_d = busy_q;
    end
    if (lat_issue && (issue_rd != ZERO_ADDR)) begin
      busy_d[issue_rd] = 1'b1;
    end else begin
      busy_d = busy_d;
    end
  end

  // Next outstanding count; overflow/underflow hold the count and flag an error.
  always_comb begin
    outstanding_d = outstanding_q;
    overflow_s    = 1'b0;
    underflow_s   = 1'b0;
    case ({lat_issue, lat_done})
      2'b10: begin
        if (outstanding_q == OUT_MAX) begin
          overflow_s = 1'b1;
        end else begin
          outstanding_d = outstanding_q + OUT_ONE;
        end
      end
      2'b01: begin
        if (outstanding_q == OUT_ZERO) begin
          underflow_s = 1'b1;
        end else begin
          outstanding_d = outstanding_q - OUT_ONE;
        end
      end
      default: outstanding_d = outstanding_q;
    endcase
  end

  // Sticky error: writeback to a non-busy register or a counter protocol violation.
  always_comb begin
    spurious_s = lat_done & (lat_done_rd != ZERO_ADDR) & ~busy_q[lat_done_rd];
    err_d      = err_q | spurious_s | overflow_s | underflow_s;
  end

  // Scoreboard state registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q        <= {NUM_REGS{1'b0}};
      outstanding_q <= {OW{1'b0}};
      err_q         <= 1'b0;
    end else begin
      busy_q        <= busy_d;
      outstanding_q <= outstanding_d;
      err_q         <= err_d;
    end
  end

  assign busy         = busy_q;
  assign outstanding  = outstanding_q;
  assign err_spurious = err_q;

endmodule

// File: rtl/fwd_hazard_ctrl.sv
// Hazard and forwarding controller for the 5-stage core: E-stage operand
// forwarding, load-use / scoreboard stalls, branch flushes, stall counter.
module fwd_hazard_ctrl
  import hazard_pkg::*;
#(
  parameter int NUM_REGS = 32,
  parameter int AW       = $clog2(NUM_REGS),
  parameter int NUM_SRC  = 2,
  parameter int MAX_OUT  = MAX_OUT_DEF,
  parameter int CNT_W    = 32
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [NUM_SRC*AW-1:0]  rs_d,
  input  logic [AW-1:0]          rd_d,
  input  logic                   reg_write_d,
  input  logic                   lat_op_d,
  input  logic [NUM_SRC*AW-1:0]  rs_e,
  input  logic [AW-1:0]          rd_e,
  input  logic                   mem_read_e,
  input  logic                   pc_src_e,
  input  logic                   lat_issue,
  input  logic                   lat_done,
  input  logic [AW-1:0]          lat_done_rd,
  input  logic [AW-1:0]          rd_m,
  input  logic                   reg_write_m,
  input  logic [AW-1:0]          rd_w,
  input  logic                   reg_write_w,
  output logic [NUM_SRC*2-1:0]   fwd_sel_e,
  output logic                   stall_f,
  output logic                   stall_d,
  output logic                   flush_d,
  output logic                   flush_e,
  output logic [CNT_W-1:0]       stall_cycles,
  output logic                   err_spurious
);

  localparam int              OW        = out_width(MAX_OUT);
  localparam logic [AW-1:0]   ZERO_ADDR = {AW{1'b0}};
  localparam logic [OW-1:0]   OUT_MAX   = OW'(MAX_OUT);
  localparam logic [CNT_W-1:0] CNT_SAT  = {CNT_W{1'b1}};

  logic [NUM_REGS-1:0] busy_s;
  logic [OW-1:0]       outstanding_s;
  logic                load_use_s, sb_raw_s, sb_waw_s, sb_full_s, hz_s;
  logic [CNT_W-1:0]    stall_cycles_q, stall_cycles_d;

  hazard_scoreboard #(
    .NUM_REGS (NUM_REGS),
    .AW       (AW),
    .MAX_OUT  (MAX_OUT),
    .OW       (OW)
  ) u_sb (
    .clk          (clk),
    .rst_n        (rst_n),
    .lat_issue    (lat_issue),
    .issue_rd     (rd_e),
    .lat_done     (lat_done),
    .lat_done_rd  (lat_done_rd),
    .busy         (busy_s),
    .outstanding  (outstanding_s),
    .err_spurious (err_spurious)
  );

  // Per-source forwarding select; M beats W, x0 never forwards.
  always_comb begin
    logic [AW-1:0] src_v;
    fwd_sel_t      sel_v;
    fwd_sel_e = {(NUM_SRC*2){1'b0}};
    for (int k = 0; k < NUM_SRC; k++) begin
      src_v = rs_e[k*AW +: AW];
      if (reg_write_m && (rd_m != ZERO_ADDR) && (rd_m == src_v)) begin
        sel_v = FWD_M;
      end else if (reg_write_w && (rd_w != ZERO_ADDR) && (rd_w == src_v)) begin
        sel_v = FWD_W;
      end else begin
        sel_v = FWD_RF;
      end
      fwd_sel_e[k*2 +: 2] = sel_v;
    end
  end

  // Decode-stage hazard terms against the load in E and the busy scoreboard.
  always_comb begin
    logic [AW-1:0] src_v;
    load_use_s = 1'b0;
    sb_raw_s   = 1'b0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src_v      = rs_d[k*AW +: AW];
      load_use_s = load_use_s | (mem_read_e & (rd_e != ZERO_ADDR) & (rd_e == src_v));
      sb_raw_s   = sb_raw_s | ((src_v != ZERO_ADDR) & busy_s[src_v]);
    end
    sb_waw_s  = reg_write_d & (rd_d != ZERO_ADDR) & busy_s[rd_d];
    sb_full_s = lat_op_d & (outstanding_s == OUT_MAX);
    hz_s      = load_use_s | sb_raw_s | sb_waw_s | sb_full_s;
  end

  // Stall/flush control; a taken branch flushes and overrides every stall.
  always_comb begin
    if (pc_src_e) begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b1;
      flush_e = 1'b1;
    end else if (hz_s) begin
      stall_f = 1'b1;
      stall_d = 1'b1;
      flush_d = 1'b0;
      flush_e = 1'b1;
    end else begin
      stall_f = 1'b0;
      stall_d = 1'b0;
      flush_d = 1'b0;
      flush_e = 1'b0;
    end
  end

  // Saturating count of decode-stall cycles.
  always_comb begin
    if (stall_d && (stall_cycles_q != CNT_SAT)) begin
      stall_cycles_d = stall_cycles_q + CNT_W'(1);
    end else begin
      stall_cycles_d = stall_cycles_q;
    end
  end

  // Stall counter register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      stall_cycles_q <= {CNT_W{1'b0}};
    end else begin
      stall_cycles_q <= stall_cycles_d;
    end
  end

  assign stall_cycles = stall_cycles_q;

endmodule

// File: tb/tb_fwd_hazard_ctrl.sv
// Self-checking bench for fwd_hazard_ctrl: directed scenarios plus random
// traffic, all checked by a queue-based scoreboard fed from a reference model.
module tb_fwd_hazard_ctrl;
  import hazard_pkg::*;

  localparam int NR = 32;
  localparam int AW = 5;
  localparam int NS = 2;
  localparam int MO = 4;
  localparam int CW = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;
  reg_addr_t rsd0, rsd1, rse0, rse1, rd_d_i, rd_e_i, done_rd_i, rd_m_i, rd_w_i;
  logic wr_d, lat_op, mem_rd, pc_src, issue, done, wr_m, wr_w;

  logic [NS*2-1:0] fwd_sel_e;
  logic            stall_f, stall_d, flush_d, flush_e, err_spurious;
  logic [CW-1:0]   stall_cycles;

  always #5 clk = ~clk;

  fwd_hazard_ctrl #(.NUM_REGS(NR), .AW(AW), .NUM_SRC(NS), .MAX_OUT(MO), .CNT_W(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .rs_d({rsd1, rsd0}), .rd_d(rd_d_i), .reg_write_d(wr_d), .lat_op_d(lat_op),
    .rs_e({rse1, rse0}), .rd_e(rd_e_i), .mem_read_e(mem_rd), .pc_src_e(pc_src),
    .lat_issue(issue), .lat_done(done), .lat_done_rd(done_rd_i),
    .rd_m(rd_m_i), .reg_write_m(wr_m), .rd_w(rd_w_i), .reg_write_w(wr_w),
    .fwd_sel_e(fwd_sel_e), .stall_f(stall_f), .stall_d(stall_d),
    .flush_d(flush_d), .flush_e(flush_e), .stall_cycles(stall_cycles),
    .err_spurious(err_spurious)
  );

  typedef struct {
    logic [3:0] fwd;
    logic       sf, sd, fd, fe, err;
    int         cnt;
  } exp_t;

  exp_t q[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  // Reference model state: set of busy registers, in-flight count, error, stall count.
  bit   busy_m[NR];
  int   out_m = 0;
  bit   err_m = 1'b0;
  int   cnt_m = 0;
  int   pend[$];

  task automatic chk(input string nm, input int act, input int expv);
    n_cmp++;
    if (act != expv) begin
      n_bad++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, expv, $time);
    end
  endtask

  function automatic logic [1:0] fwd_exp(input reg_addr_t rs);
    if (wr_m && rd_m_i != 5'd0 && rd_m_i == rs) return 2'b10;
    if (wr_w && rd_w_i != 5'd0 && rd_w_i == rs) return 2'b01;
    return 2'b00;
  endfunction

  task automatic idle();
    {rsd0, rsd1, rse0, rse1, rd_d_i, rd_e_i, done_rd_i, rd_m_i, rd_w_i} = '0;
    {wr_d, lat_op, mem_rd, pc_src, issue, done, wr_m, wr_w} = '0;
  endtask

  task automatic model_clear();
    for (int i = 0; i < NR; i++) busy_m[i] = 1'b0;
    out_m = 0; err_m = 1'b0; cnt_m = 0;
    pend.delete();
  endtask

  // Push the expected response for the current inputs, advance the model, move to next cycle.
  task automatic step();
    exp_t e;
    bit lu, raw, waw, full, hz;
    e.fwd = {fwd_exp(rse1), fwd_exp(rse0)};
    lu   = mem_rd && rd_e_i != 5'd0 && (rd_e_i == rsd0 || rd_e_i == rsd1);
    raw  = (rsd0 != 5'd0 && busy_m[rsd0]) || (rsd1 != 5'd0 && busy_m[rsd1]);
    waw  = wr_d && rd_d_i != 5'd0 && busy_m[rd_d_i];
    full = lat_op && out_m == MO;
    hz   = lu || raw || waw || full;
    if (pc_src) begin
      e.sf = 1'b0; e.sd = 1'b0; e.fd = 1'b1; e.fe = 1'b1;
    end else if (hz) begin
      e.sf = 1'b1; e.sd = 1'b1; e.fd = 1'b0; e.fe = 1'b1;
    end else begin
      e.sf = 1'b0; e.sd = 1'b0; e.fd = 1'b0; e.fe = 1'b0;
    end
    e.cnt = cnt_m;
    e.err = err_m;
    q.push_back(e);
    if (done && done_rd_i != 5'd0 && !busy_m[done_rd_i]) err_m = 1'b1;
    if (issue && !done) begin
      if (out_m == MO) err_m = 1'b1; else out_m++;
    end else if (done && !issue) begin
      if (out_m == 0) err_m = 1'b1; else out_m--;
    end
    if (done && done_rd_i != 5'd0) busy_m[done_rd_i] = 1'b0;
    if (issue && rd_e_i != 5'd0) busy_m[rd_e_i] = 1'b1;
    if (e.sd && cnt_m < (1 << CW) - 1) cnt_m++;
    @(posedge clk);
    #1;
  endtask

  // Asynchronous reset pulse away from any clock edge.
  task automatic do_reset();
    idle();
    rst_n = 1'b0;
    #1;
    chk("rst_stall_cycles", int'(stall_cycles), 0);
    chk("rst_err", int'(err_spurious), 0);
    chk("rst_outstanding", int'(dut.outstanding_s), 0);
    chk("rst_busy", int'(dut.busy_s), 0);
    chk("rst_stall_d", int'(stall_d), 0);
    model_clear();
    #1;
    rst_n = 1'b1;
    #1;
  endtask

  // Monitor: every cycle the DUT presents outputs, compare against the oldest expectation.
  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("fwd_sel_e", int'(fwd_sel_e), int'(e.fwd));
        chk("stall_f", int'(stall_f), int'(e.sf));
        chk("stall_d", int'(stall_d), int'(e.sd));
        chk("flush_d", int'(flush_d), int'(e.fd));
        chk("flush_e", int'(flush_e), int'(e.fe));
        chk("stall_cycles", int'(stall_cycles), e.cnt);
        chk("err_spurious", int'(err_spurious), int'(e.err));
      end
    end
  end

  initial begin
    int wait_cyc;
    idle();
    model_clear();
    #12;
    chk("reset_stall_cycles", int'(stall_cycles), 0);
    chk("reset_err", int'(err_spurious), 0);
    chk("reset_fwd", int'(fwd_sel_e), 0);
    chk("reset_flush_e", int'(flush_e), 0);
    rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Forwarding priority: M over W, x0 never forwards.
    rse0 = 5'd5; rd_m_i = 5'd5; wr_m = 1'b1; rd_w_i = 5'd5; wr_w = 1'b1;
    #1 chk("fwd_m_prio", int'(fwd_sel_e[1:0]), 2);
    step();
    rd_m_i = 5'd0;
    #1 chk("fwd_w", int'(fwd_sel_e[1:0]), 1);
    step();
    rd_w_i = 5'd0;
    #1 chk("fwd_rf", int'(fwd_sel_e[1:0]), 0);
    step();

    // Load-use: one bubble, counter 0 -> 1.
    idle(); mem_rd = 1'b1; rd_e_i = 5'd7; rsd1 = 5'd7;
    #1 chk("lu_stall", int'(stall_d), 1);
    step();
    idle(); rsd1 = 5'd7;
    #1 chk("lu_release", int'(stall_d), 0);
    chk("lu_count", int'(stall_cycles), 1);
    step();

    // Long op to x9 with a dependent instruction held in D.
    idle(); issue = 1'b1; rd_e_i = 5'd9; rsd0 = 5'd9;
    step();
    idle(); rsd0 = 5'd9;
    for (int i = 0; i < 4; i++) step();
    done = 1'b1; done_rd_i = 5'd9;
    #1 chk("lat_done_cycle_stall", int'(stall_d), 1);
    step();
    idle(); rsd0 = 5'd9;
    #1 chk("lat_after_done", int'(stall_d), 0);
    chk("outstanding_zero", int'(dut.outstanding_s), 0);
    step();

    // Outstanding limit: four in flight blocks a new long op until one retires.
    for (int i = 1; i <= 4; i++) begin
      idle(); issue = 1'b1; rd_e_i = 5'(i + 20);
      step();
    end
    idle(); lat_op = 1'b1;
    #1 chk("full_stall", int'(stall_d), 1);
    step();
    lat_op = 1'b1; done = 1'b1; done_rd_i = 5'd21;
    step();
    idle(); lat_op = 1'b1;
    #1 chk("full_release", int'(stall_d), 0);
    step();

    // Branch flush overrides a load-use stall.
    idle(); pc_src = 1'b1; mem_rd = 1'b1; rd_e_i = 5'd7; rsd0 = 5'd7;
    #1 chk("br_flush_d", int'(flush_d), 1);
    chk("br_stall_d", int'(stall_d), 0);
    step();

    // Spurious writeback raises the sticky error at the next edge.
    idle(); done = 1'b1; done_rd_i = 5'd12;
    #1 chk("spur_before", int'(err_spurious), 0);
    step();
    idle();
    #1 chk("spur_after", int'(err_spurious), 1);
    step();
    step();
    do_reset();

    // Overflow: fifth issue with four outstanding.
    for (int i = 0; i < 5; i++) begin
      idle(); issue = 1'b1; rd_e_i = 5'(i + 1);
      step();
    end
    idle();
    #1 chk("ovf_err", int'(err_spurious), 1);
    step();
    do_reset();

    // Random traffic with one reset partway through.
    for (int c = 0; c < 600; c++) begin
      if (c == 300) do_reset();
      rsd0 = 5'($urandom_range(0, 7)); rsd1 = 5'($urandom_range(0, 7));
      rse0 = 5'($urandom_range(0, 7)); rse1 = 5'($urandom_range(0, 7));
      rd_d_i = 5'($urandom_range(0, 7)); rd_e_i = 5'($urandom_range(0, 7));
      rd_m_i = 5'($urandom_range(0, 7)); rd_w_i = 5'($urandom_range(0, 7));
      wr_d = 1'($urandom % 2); wr_m = 1'($urandom % 2); wr_w = 1'($urandom % 2);
      lat_op = 1'($urandom % 3 == 0);
      mem_rd = 1'($urandom % 4 == 0);
      pc_src = 1'($urandom % 8 == 0);
      issue = ($urandom % 4 == 0) && (pend.size() < MO || $urandom % 10 == 0);
      done = 1'b0; done_rd_i = 5'd0;
      if (pend.size() > 0 && $urandom % 3 == 0) begin
        done = 1'b1; done_rd_i = 5'(pend.pop_front());
      end else if ($urandom % 60 == 0) begin
        done = 1'b1; done_rd_i = 5'($urandom_range(0, 31));
      end
      if (issue) pend.push_back(int'(rd_e_i));
      step();
    end

    idle();
    wait_cyc = 0;
    while (q.size() > 0 && wait_cyc < 10) begin
      @(posedge clk);
      wait_cyc++;
    end
    chk("queue_drained", q.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
